nes_pad_poller: RTL
===================

NES_PAD_POLLER -- requirements
Module: nes_pad_poller

Interface
REQ-001 SHALL have parameter HALF_CYC, default 150, meaning clk cycles per NES clock half-period (6 us at 25.175 MHz); legal range 2..1023.
REQ-002 SHALL have clk  input  1  system clock; the block uses one clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have poll  input  1  one-cycle poll request (driven from frame_end).
REQ-005 SHALL have enable  input  1  when 0, new polls are refused.
REQ-006 SHALL have nes_data  input  1  serial pad data, active-low (0 = pressed).
REQ-007 SHALL have nes_latch  output  1  pad latch strobe, registered.
REQ-008 SHALL have nes_clk  output  1  pad shift clock, registered.
REQ-009 SHALL have buttons  output  8  pressed=1; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-010 SHALL have buttons_valid  output  1  one-cycle pulse when buttons updates.
REQ-011 SHALL have pad_present  output  1  1 when the last poll saw a connected pad.
REQ-012 SHALL have busy  output  1  high while a poll sequence runs.
REQ-013 SHALL have poll_missed  output  1  one-cycle pulse when a poll is refused.

Function
REQ-014 SHALL implement the FSM states IDLE, LATCH, LOW, HIGH and DONE.
REQ-015 IDLE: when poll=1 and enable=1, the FSM SHALL go to LATCH on the next edge; otherwise it stays in IDLE.
REQ-016 LATCH SHALL last 2*HALF_CYC cycles with nes_latch=1, and SHALL sample nes_data into shift bit 0 on its last cycle.
REQ-017 LOW SHALL last HALF_CYC cycles with nes_clk=0 and nes_latch=0, then go to HIGH.
REQ-018 HIGH SHALL last HALF_CYC cycles with nes_clk=1, and SHALL sample nes_data into the next shift bit on its last cycle.
REQ-019 LOW/HIGH SHALL repeat exactly 7 times, capturing bits 1..7, tracked by a 3-bit pulse counter.
REQ-020 After the 7th HIGH, the FSM SHALL enter DONE for 1 cycle; DONE SHALL update buttons, pad_present and buttons_valid together, then return to IDLE.
REQ-021 Latency: buttons_valid SHALL assert exactly 16*HALF_CYC+1 cycles after the edge that accepts poll.
REQ-022 buttons SHALL equal the bitwise inverse of the 8 sampled raw bits.
REQ-023 If all 8 raw bits are 0 (line held low, no pad), the block SHALL set pad_present=0 and force buttons to 8'h00.
REQ-024 Otherwise, the block SHALL set pad_present=1.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A poll while busy=1, or while enable=0, SHALL be ignored and SHALL pulse poll_missed in the following cycle.
REQ-027 Deasserting enable mid-sequence SHALL NOT abort the sequence.
REQ-028 buttons and pad_present SHALL hold their values between DONE events.
REQ-029 nes_latch and nes_clk SHALL never be high in the same cycle.
REQ-030 The phase counter SHALL be 10 bits wide, count HALF_CYC-1 down to 0, and reload on every state change; it SHALL not wrap past 0.

Reset
REQ-031 While rst_n=0, the block SHALL force the FSM to IDLE and clear all counters and the shift register.
REQ-032 While rst_n=0, the block SHALL drive nes_latch=0, nes_clk=0, buttons=8'h00, buttons_valid=0, pad_present=0, busy=0 and poll_missed=0.
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence with no buttons_valid pulse.
REQ-034 After reset release, the block SHALL wait in IDLE for a fresh poll.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the button bit index constants and the DEFAULT_HALF_CYC constant.
REQ-036 The half-period down-counter with terminal-count flag SHALL be one sub-module named nes_phase_timer; the FSM and shift register stay in nes_pad_poller.

Verification
REQ-037 HALF_CYC=4, pad model returning raw 8'b1111_1110 -> buttons=8'h01 (A), pad_present=1, buttons_valid at cycle 65 after accept.
REQ-038 Raw 8'b0111_1111 -> buttons=8'h80 (Right); 7 nes_clk pulses of 4 cycles each; nes_latch high 8 cycles.
REQ-039 nes_data held 0 -> pad_present=0, buttons=8'h00; nes_data held 1 -> pad_present=1, buttons=8'h00.
REQ-040 poll re-pulsed at cycle 10 of a sequence -> poll_missed pulse, sequence unaffected; poll with enable=0 -> poll_missed, busy stays 0.
REQ-041 rst_n low during the 3rd HIGH -> outputs at reset values immediately, no buttons_valid; next poll completes normally.
REQ-042 All scenarios -> assertion that nes_latch and nes_clk are never both 1 and buttons_valid is exactly one cycle wide.

Source files
------------

// File: rtl/nes_pad_poller_pkg.sv
// Shared definitions for the NES pad poller: FSM encoding, button bit
// positions and the default half-period length.
package nes_pad_poller_pkg;

    localparam int DEFAULT_HALF_CYC = 150;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/nes_phase_timer.sv
// Half-period down-counter: reloads to HALF_CYC-1 on load, stops at zero,
// and flags the terminal count while it sits at zero.
module nes_phase_timer #(
    parameter int HALF_CYC = 150
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);

    localparam logic [9:0] RELOAD = 10'(HALF_CYC - 1);

    logic [9:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != 10'd0) begin
            cnt <= cnt - 10'd1;
        end
    end

    assign tc = (cnt == 10'd0);

endmodule

// File: rtl/nes_pad_poller.sv
// NES controller poller: on a poll request, strobes latch, clocks out eight
// serial bits, and publishes the decoded, active-high button state.
module nes_pad_poller
    import nes_pad_poller_pkg::*;
#(
    parameter int HALF_CYC = DEFAULT_HALF_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       poll,
    input  logic       enable,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       pad_present,
    output logic       busy,
    output logic       poll_missed
);

    state_e     state, state_nx;
    logic       load;
    logic       tc;
    logic       sample;
    logic       latch_half;
    logic [2:0] pulse_cnt;
    logic [2:0] bit_idx;
    logic [7:0] sh;

    nes_phase_timer #(
        .HALF_CYC (HALF_CYC)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .tc    (tc)
    );

    // LATCH spans two half-periods; the timer is reloaded at the midpoint
    // so it never needs to hold more than HALF_CYC-1.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        sample   = 1'b0;
        case (state)
            ST_IDLE: begin
                load = 1'b1;
                if (poll && enable) state_nx = ST_LATCH;
            end
            ST_LATCH: begin
                if (tc) begin
                    if (!latch_half) begin
                        load = 1'b1;
                    end else begin
                        sample   = 1'b1;
                        state_nx = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (tc) state_nx = ST_HIGH;
            end
            ST_HIGH: begin
                if (tc) begin
                    sample   = 1'b1;
                    state_nx = (pulse_cnt == 3'd6) ? ST_DONE : ST_LOW;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (state_nx != state) load = 1'b1;
    end

    assign bit_idx = (state == ST_LATCH) ? 3'd0 : (pulse_cnt + 3'd1);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            latch_half <= 1'b0;
            pulse_cnt  <= 3'd0;
            sh         <= 8'h00;
        end else begin
            state <= state_nx;

            if (state == ST_LATCH && tc && !latch_half) latch_half <= 1'b1;
            else if (state != ST_LATCH)                 latch_half <= 1'b0;

            if (state == ST_IDLE)        pulse_cnt <= 3'd0;
            else if (state == ST_HIGH && tc) pulse_cnt <= pulse_cnt + 3'd1;

            if (state == ST_IDLE) sh <= 8'h00;
            else if (sample)      sh[bit_idx] <= nes_data;
        end
    end

    // Pad lines are driven from the next state so they line up exactly with
    // the state they belong to while still coming straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nes_latch     <= 1'b0;
            nes_clk       <= 1'b0;
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
            pad_present   <= 1'b0;
            poll_missed   <= 1'b0;
        end else begin
            nes_latch     <= (state_nx == ST_LATCH);
            nes_clk       <= (state_nx == ST_HIGH);
            buttons_valid <= (state == ST_DONE);
            poll_missed   <= poll && ((state != ST_IDLE) || !enable);
            // A line stuck low reads as all-pressed; treat it as no pad.
            if (state == ST_DONE) begin
                pad_present <= (sh != 8'h00);
                buttons     <= (sh != 8'h00) ? ~sh : 8'h00;
            end
        end
    end

endmodule
